// File: rtl/systolic_pkg.sv
// Array-level constants shared by every processing element in the systolic grid.
package systolic_pkg;

  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/pe_mac.sv
// Combinational multiply-accumulate step for one PE: acc + u*l, then wrap or clamp.
module pe_mac
  import systolic_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter bit SATURATE = 1'b0
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] u_i,
  input  logic [DATA_W-1:0] l_i,
  output logic [DATA_W-1:0] acc_o
);

  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W:0]   sum;

  // Any bit above the accumulator width means the sum exceeded the maximum value.
  function automatic logic [DATA_W-1:0] fold_sum(input logic [2*DATA_W:0] s);
    if (SATURATE && (s[2*DATA_W:DATA_W] != '0)) begin
      fold_sum = '1;
    end else begin
      fold_sum = s[DATA_W-1:0];
    end
  endfunction

  assign prod  = u_i * l_i;
  assign sum   = {1'b0, prod} + {{(DATA_W+1){1'b0}}, acc_i};
  assign acc_o = fold_sum(sum);

endmodule

// File: rtl/systolic_pe.sv
// Systolic-array processing element: forwards operands down/right and accumulates their product.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:DATA_W-1] u,
  input  logic [0:DATA_W-1] l,
  output logic [0:DATA_W-1] d,
  output logic [0:DATA_W-1] r,
  output logic [0:DATA_W-1] out
);

  logic [DATA_W-1:0] d_q;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;
  logic [DATA_W-1:0] u_in;
  logic [DATA_W-1:0] l_in;

  assign u_in = u;
  assign l_in = l;

  pe_mac #(
    .DATA_W  (DATA_W),
    .SATURATE(SATURATE)
  ) u_mac (
    .acc_i(acc_q),
    .u_i  (u_in),
    .l_i  (l_in),
    .acc_o(acc_d)
  );

  // Reset clears the accumulator too: it is the only way to start a new dot product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q   <= '0;
      r_q   <= '0;
      acc_q <= '0;
    end else begin
      d_q   <= u_in;
      r_q   <= l_in;
      acc_q <= acc_d;
    end
  end

  assign d   = d_q;
  assign r   = r_q;
  assign out = acc_q;

endmodule

// File: tb/tb_systolic_pe.sv
// Directed bench for systolic_pe: one wrapping and one saturating instance share the stimulus.
module tb_systolic_pe;

  logic       clk;
  logic       rst;
  logic [0:7] u;
  logic [0:7] l;
  logic [0:7] d_w, r_w, out_w;
  logic [0:7] d_s, r_s, out_s;

  int n_cmp;
  int n_bad;

  systolic_pe #(.DATA_W(8), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .u(u), .l(l), .d(d_w), .r(r_w), .out(out_w)
  );

  systolic_pe #(.DATA_W(8), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .u(u), .l(l), .d(d_s), .r(r_s), .out(out_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_all(input string tag);
    chk({tag, "_d_w"}, d_w, 0);
    chk({tag, "_r_w"}, r_w, 0);
    chk({tag, "_out_w"}, out_w, 0);
    chk({tag, "_d_s"}, d_s, 0);
    chk({tag, "_r_s"}, r_s, 0);
    chk({tag, "_out_s"}, out_s, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    u = 8'd9;
    l = 8'd9;
    step();
    step();

    // Asynchronous reset between edges, then held across two edges.
    #2;
    rst = 1'b0;
    #1;
    zero_all("rst_async");
    step();
    step();
    zero_all("rst_hold");

    // Single MAC after release.
    #2;
    rst = 1'b1;
    u = 8'd7;
    l = 8'd5;
    step();
    chk("mac_d", d_w, 7);
    chk("mac_r", r_w, 5);
    chk("mac_out_w", out_w, 35);
    chk("mac_out_s", out_s, 35);

    // Reset mid-accumulation, then accumulate again.
    #2;
    rst = 1'b0;
    #1;
    zero_all("rst_mid");
    rst = 1'b1;
    u = 8'd3;
    l = 8'd2;
    step();
    chk("acc1_out", out_w, 6);
    step();
    chk("acc2_out", out_w, 12);
    u = 8'd12;
    l = 8'd7;
    step();
    chk("acc3_out_w", out_w, 96);
    chk("acc3_out_s", out_s, 96);
    chk("acc3_d", d_s, 12);
    chk("acc3_r", r_s, 7);

    // Consecutive accumulation from a fresh reset.
    pulse_reset();
    u = 8'd3;
    l = 8'd2;
    step();
    chk("seq1_out", out_w, 6);
    u = 8'd12;
    l = 8'd7;
    step();
    chk("seq2_out", out_w, 90);

    // Overflow: wrap versus clamp.
    pulse_reset();
    u = 8'd16;
    l = 8'd16;
    step();
    chk("ovf1_out_w", out_w, 0);
    chk("ovf1_out_s", out_s, 255);
    step();
    chk("ovf2_out_w", out_w, 0);
    chk("ovf2_out_s", out_s, 255);
    u = 8'd0;
    l = 8'd0;
    step();
    chk("ovf_hold_s", out_s, 255);
    chk("ovf_hold_w", out_w, 0);

    // Landing exactly on the maximum does not saturate early; one more unit does.
    pulse_reset();
    u = 8'd15;
    l = 8'd15;
    step();
    chk("edge1_out_s", out_s, 225);
    u = 8'd1;
    l = 8'd30;
    step();
    chk("edge2_out_w", out_w, 255);
    chk("edge2_out_s", out_s, 255);
    chk("edge2_d", d_w, 1);
    chk("edge2_r", r_w, 30);
    u = 8'd1;
    l = 8'd1;
    step();
    chk("edge3_out_w", out_w, 0);
    chk("edge3_out_s", out_s, 255);

    // Reset held low across a clock edge with live operands wins.
    @(negedge clk);
    u = 8'd200;
    l = 8'd3;
    rst = 1'b0;
    step();
    zero_all("rst_edge");
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_pe.md
# systolic_pe

Multiply-accumulate processing element for the systolic-array convolution datapath. Each clock it registers the operand arriving from above (`u`) and from the left (`l`), forwards them unchanged to the cell below (`d`) and to the right (`r`), and adds their product into a local accumulator presented on `out`. An N×M grid of these cells, chained through `d` and `r`, forms the array.

## Interface
Parameters:
- `DATA_W`, default 8: width of the operands, the forwarded outputs and `out`.
- `SATURATE`, default 0: 0 means the accumulator wraps modulo 2^DATA_W; 1 means it clamps at 2^DATA_W−1.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `u`  in  DATA_W  operand from the cell above, unsigned.
- `l`  in  DATA_W  operand from the cell to the left, unsigned.
- `d`  out  DATA_W  registered copy of `u`, feeds the cell below.
- `r`  out  DATA_W  registered copy of `l`, feeds the cell to the right.
- `out`  out  DATA_W  accumulator value.

All buses are declared `[0:DATA_W-1]`, so index 0 is the MSB. Values are plain unsigned binary.

## Operation
- Reset (`rst`=0): `d`, `r` and `out` are forced to 0 immediately, with no clock needed, and are held at 0 while `rst` is low.
- Every rising edge with `rst`=1:
  - `d` ← `u`, `r` ← `l`.
  - `out` ← `out` + `u`·`l`.
- There is no enable and no handshake: the cell accumulates on every cycle, and the upstream sequencer zeroes the operands when it wants an idle cycle.
- Arithmetic:
  - The product `u`·`l` is computed at full 2·DATA_W width (unsigned), and the sum is formed at 2·DATA_W+1 bits.
  - SATURATE=0: `out` takes the low DATA_W bits of the sum.
  - SATURATE=1: if the sum is greater than 2^DATA_W−1, `out` takes 2^DATA_W−1. Once saturated it stays there until reset.
- The only way to clear the accumulator is reset. Resetting mid-operation discards the accumulated value and the forwarded operands.

## Timing
- `d` and `r` have 1-cycle latency from `u` and `l`.
- `out` reflects the product of the operands sampled at the current edge, added to the previous value, with 1-cycle latency.
- All outputs come straight from registers, with no combinational path from inputs to outputs.
- Reset release: the first edge with `rst`=1 performs a normal update from the all-zero state. Reset deassertion must meet the recovery and removal constraints relative to `clk`.
- Reset asserted while a clock edge occurs: reset wins and all outputs are 0.

## Structure
- Single module `systolic_pe`; a shared package is not needed.
- Natural split: a sub-module `pe_mac` that is purely combinational and holds the multiply, add and optional saturation logic. The forwarding registers and the accumulator register live in `systolic_pe`.
- The array-level package (`systolic_pkg`) provides the default `DATA_W` as a constant, so every PE in the grid agrees on it.

## Test plan
- Reset: drive `rst`=0 asynchronously between clock edges → `d`=`r`=`out`=0 at once. Hold for 2 edges → still 0.
- Single MAC: release reset, apply `u`=7, `l`=5, one edge → `d`=7, `r`=5, `out`=35.
- Reset mid-accumulation: after the previous case, pulse `rst` low for 1 ns between edges → all outputs 0. Apply `u`=3, `l`=2, one edge → `out`=6. Second edge → `out`=12. Then `u`=12, `l`=7, one edge → `out`=96, `d`=12, `r`=7.
- Consecutive accumulation after reset: `u`=3, `l`=2 for one edge, then `u`=12, `l`=7 for one edge → `out`=6 then 90.
- Wrap, SATURATE=0: `u`=`l`=16, two edges → `out`=0 (512 mod 256).
- Saturate, SATURATE=1: `u`=`l`=16, one edge → `out`=255. Then `u`=`l`=0 → `out` stays 255.
